// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and default sync depth.
// Callers size-cast the arguments and results to their own pointer width.
package fifo_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int PTR_MAX_W           = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ {1'b0, bin[PTR_MAX_W-1:1]};
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits do not disturb the result.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/pntr_sync.sv
// N-stage flop chain carrying a Gray pointer across a clock-domain boundary.
// Shared by the read-side empty logic and the write-side full logic.
module pntr_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_r [STAGES];

  // Shift register: stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/rd_ctrl_sync.sv
// Read-domain controller for a dual-clock FIFO: read pointers, empty/almost-empty,
// fill count and underflow, with the write Gray pointer synchronised internally.
module rd_ctrl_sync
  import fifo_pkg::*;
#(
  parameter int AWIDTH           = 3,
  parameter int SYNC_STAGES      = DEFAULT_SYNC_STAGES,
  parameter int ALMOST_EMPTY_LVL = 1,
  parameter int SHOWAHEAD        = 0
) (
  input  logic              rd_clk_i,
  input  logic              aclr_n_i,
  input  logic              rd_req_i,
  input  logic [AWIDTH:0]   wr_pntr_gray_i,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic [AWIDTH:0]   rd_pntr_gray_o,
  output logic              rd_empty_o,
  output logic              rd_almost_empty_o,
  output logic [AWIDTH:0]   rd_usedw_o,
  output logic              rd_underflow_o
);

  localparam int            PW     = AWIDTH + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LVL);

  logic [PW-1:0] wr_gray_sync_s;
  logic [PW-1:0] wr_bin_sync_s;
  logic [PW-1:0] rd_bin_r;
  logic [PW-1:0] rd_bin_next_s;
  logic [PW-1:0] rd_gray_next_s;
  logic [PW-1:0] usedw_next_s;
  logic          rd_en_s;

  pntr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk    (rd_clk_i),
    .aclr_n (aclr_n_i),
    .din    (wr_pntr_gray_i),
    .dout   (wr_gray_sync_s)
  );

  // Next-pointer arithmetic; the extra pointer bit makes full and empty distinguishable.
  always_comb begin
    wr_bin_sync_s  = PW'(gray2bin(PTR_MAX_W'(wr_gray_sync_s)));
    rd_en_s        = rd_req_i & ~rd_empty_o;
    rd_bin_next_s  = rd_bin_r + {{AWIDTH{1'b0}}, rd_en_s};
    rd_gray_next_s = PW'(bin2gray(PTR_MAX_W'(rd_bin_next_s)));
    usedw_next_s   = wr_bin_sync_s - rd_bin_next_s;
    if (SHOWAHEAD != 32'sd0) begin
      rd_pntr_o = rd_bin_next_s[AWIDTH-1:0];
    end else begin
      rd_pntr_o = rd_bin_r[AWIDTH-1:0];
    end
  end

  // Flags are computed from the post-pop pointer so a last-word pop flags empty at once.
  always_ff @(posedge rd_clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      rd_bin_r          <= '0;
      rd_pntr_gray_o    <= '0;
      rd_empty_o        <= 1'b1;
      rd_almost_empty_o <= 1'b1;
      rd_usedw_o        <= '0;
      rd_underflow_o    <= 1'b0;
    end else begin
      rd_bin_r          <= rd_bin_next_s;
      rd_pntr_gray_o    <= rd_gray_next_s;
      rd_empty_o        <= (rd_gray_next_s == wr_gray_sync_s);
      rd_almost_empty_o <= (usedw_next_s <= AE_LVL);
      rd_usedw_o        <= usedw_next_s;
      rd_underflow_o    <= rd_req_i & rd_empty_o;
    end
  end

endmodule

// File: tb/tb_rd_ctrl_sync.sv
// Directed-plus-random bench for rd_ctrl_sync against a counting reference model.
module tb_rd_ctrl_sync;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int LAP   = 16;
  localparam int SYNC  = 2;

  logic          clk = 1'b0;
  logic          aclr_n = 1'b0;
  logic          req = 1'b0;
  int            wr_bin = 0;
  logic [AW:0]   wr_gray;

  logic [AW-1:0] pntr0, pntr1;
  logic [AW:0]   gray0, gray1, usedw0, usedw1;
  logic          empty0, empty1, ae0, ae1, uf0, uf1;

  int checks = 0;
  int errors = 0;

  // Reference model: read count, visible write count (delayed by the sync depth), flags.
  int m_rd = 0;
  int m_usedw = 0;
  bit m_empty = 1'b1;
  bit m_ae = 1'b1;
  bit m_uf = 1'b0;
  int pipe[$];

  assign wr_gray = 4'(wr_bin) ^ 4'(wr_bin >> 1);

  always #5 clk = ~clk;

  rd_ctrl_sync #(.AWIDTH(AW), .SYNC_STAGES(SYNC), .ALMOST_EMPTY_LVL(1), .SHOWAHEAD(0)) dut0 (
    .rd_clk_i(clk), .aclr_n_i(aclr_n), .rd_req_i(req), .wr_pntr_gray_i(wr_gray),
    .rd_pntr_o(pntr0), .rd_pntr_gray_o(gray0), .rd_empty_o(empty0),
    .rd_almost_empty_o(ae0), .rd_usedw_o(usedw0), .rd_underflow_o(uf0)
  );

  rd_ctrl_sync #(.AWIDTH(AW), .SYNC_STAGES(SYNC), .ALMOST_EMPTY_LVL(1), .SHOWAHEAD(1)) dut1 (
    .rd_clk_i(clk), .aclr_n_i(aclr_n), .rd_req_i(req), .wr_pntr_gray_i(wr_gray),
    .rd_pntr_o(pntr1), .rd_pntr_gray_o(gray1), .rd_empty_o(empty1),
    .rd_almost_empty_o(ae1), .rd_usedw_o(usedw1), .rd_underflow_o(uf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_usedw = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    pipe.delete();
    for (int i = 0; i < SYNC; i++) pipe.push_back(0);
  endtask

  // One rd_clk edge; the model advances from the inputs held across the edge.
  task automatic tick();
    int vis;
    @(posedge clk);
    vis = pipe.pop_front();
    pipe.push_back(wr_bin);
    m_uf = req && m_empty;
    if (req && !m_empty) m_rd = (m_rd + 1) % LAP;
    m_usedw = (vis - m_rd + LAP) % LAP;
    m_empty = (m_usedw == 0);
    m_ae = (m_usedw <= 1);
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".empty"}, 32'(empty0), 32'(m_empty));
    chk({tag, ".ae"}, 32'(ae0), 32'(m_ae));
    chk({tag, ".usedw"}, 32'(usedw0), 32'(m_usedw));
    chk({tag, ".uf"}, 32'(uf0), 32'(m_uf));
    chk({tag, ".gray"}, 32'(gray0), 32'(m_rd ^ (m_rd >> 1)));
    chk({tag, ".pntr"}, 32'(pntr0), 32'(m_rd % DEPTH));
    chk({tag, ".usedw_sa"}, 32'(usedw1), 32'(m_usedw));
    chk({tag, ".pntr_sa"}, 32'(pntr1), 32'((m_rd + ((req && !m_empty) ? 1 : 0)) % DEPTH));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".empty"}, 32'(empty0), 32'd1);
    chk({tag, ".ae"}, 32'(ae0), 32'd1);
    chk({tag, ".usedw"}, 32'(usedw0), 32'd0);
    chk({tag, ".gray"}, 32'(gray0), 32'd0);
    chk({tag, ".uf"}, 32'(uf0), 32'd0);
    chk({tag, ".pntr"}, 32'(pntr0), 32'd0);
  endtask

  initial begin
    logic [AW:0] prev_gray;
    model_reset();

    // 1. Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      req = 1'(i);
      wr_bin = $urandom_range(1, 15);
      @(posedge clk); #1;
      chk_reset_vals("rst_hold");
    end
    req = 1'b0; wr_bin = 0; aclr_n = 1'b1;
    tick(); compare_all("rst_rel");

    // 2. Sync latency: one word becomes visible on the third edge.
    wr_bin = 1;
    tick(); chk("lat_e1", 32'(empty0), 32'd1);
    tick(); chk("lat_e2", 32'(empty0), 32'd1);
    tick(); chk("lat_e3", 32'(empty0), 32'd0);
    chk("lat_usedw", 32'(usedw0), 32'd1);
    chk("lat_ae", 32'(ae0), 32'd1);
    compare_all("lat");

    // 3. Fill to depth, then drain with a held request.
    wr_bin = 8;
    for (int i = 0; i < 3; i++) tick();
    chk("full_usedw", 32'(usedw0), 32'd8);
    chk("full_empty", 32'(empty0), 32'd0);
    req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pntr", 32'(pntr0), 32'(i));
      tick();
      chk("drain_usedw", 32'(usedw0), 32'(7 - i));
      compare_all("drain");
    end
    chk("drain_gray", 32'(gray0), 32'hc);
    chk("drain_empty", 32'(empty0), 32'd1);

    // 4. Underflow: requests while empty never move the pointer.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("uf_pulse", 32'(uf0), 32'd1);
      chk("uf_usedw", 32'(usedw0), 32'd0);
      chk("uf_pntr", 32'(pntr0), 32'd0);
      compare_all("uf");
    end

    // 5. Random interleaved writes/reads across the pointer wrap.
    req = 1'b0;
    prev_gray = gray0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0 && ((wr_bin - m_rd + LAP) % LAP) < DEPTH)
        wr_bin = (wr_bin + 1) % LAP;
      req = 1'($urandom_range(0, 1));
      tick();
      compare_all("wrap");
      if (gray0 !== prev_gray) chk("wrap_gray1bit", 32'($countones(gray0 ^ prev_gray)), 32'd1);
      prev_gray = gray0;
    end

    // Reset asserted mid-read takes effect immediately.
    req = 1'b1;
    if (((wr_bin - m_rd + LAP) % LAP) < DEPTH) wr_bin = (wr_bin + 1) % LAP;
    @(posedge clk); #3;
    aclr_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    chk("rst_mid_sa_pntr", 32'(pntr1), 32'd0);
    model_reset();
    @(posedge clk); #1;
    req = 1'b0; wr_bin = 0; aclr_n = 1'b1;

    // 6. Show-ahead addressing with three words queued.
    wr_bin = 3;
    for (int i = 0; i < 3; i++) tick();
    chk("sa_usedw", 32'(usedw1), 32'd3);
    chk("sa_idle_pntr", 32'(pntr1), 32'd0);
    req = 1'b1; #1;
    chk("sa_pop_pntr", 32'(pntr1), 32'd1);
    chk("sa_norm_pntr", 32'(pntr0), 32'd0);
    tick(); compare_all("sa");
    chk("sa_pop2_pntr", 32'(pntr1), 32'd2);
    req = 1'b0; #1;
    chk("sa_idle2_pntr", 32'(pntr1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
